genius_control: RTL and testbench
=================================

// Module: genius_control
// PURPOSE
//  Control unit for the Genius game; the stage directly upstream of the datapath.
//  Debounces the player keys and runs the game FSM.
//  Consumes datapath status: end_FPGA, end_User, end_time, win, match.
//  Drives datapath controls R1, R2, E1..E4 and SEL.
// PARAMETERS
//  DEBOUNCE_CYCLES  1_000_000  clocks a key must be stable to be accepted (20 ms @ 50 MHz)
//  P_KEY            4          width of raw KEY bus
// PORTS
//  CLOCK_50   in   1      system clock, 50 MHz; all logic on rising edge
//  reset      in   1      synchronous, active-high; forces INIT
//  KEY        in   P_KEY  raw push-buttons, active-low; KEY[0]=enter, KEY[1]=restart, others unused
//  end_FPGA   in   1      datapath finished showing the sequence
//  end_User   in   1      player has entered the full sequence for this round
//  end_time   in   1      input timer expired
//  win        in   1      round counter terminal count
//  match      in   1      last player entry equals expected element
//  R1         out  1      datapath global reset (round, clocks)
//  R2         out  1      timer reset
//  E1         out  1      SETUP register load from SWITCH
//  E2         out  1      timer count enable
//  E3         out  1      FPGA sequence playback enable
//  E4         out  1      round counter increment (1-cycle pulse)
//  SEL        out  1      display select: 0 = game info, 1 = result
//  state_o    out  3      current state encoding, for debug LEDs
// BEHAVIOUR
//  Key conditioning, per used key:
//  - 2-FF synchroniser.
//  - Stability counter; accepted level changes after DEBOUNCE_CYCLES equal samples; counter restarts on any change.
//  - Accepted falling edge (press) gives one 1-cycle pulse: enter_p or restart_p.
//  - Holding a key gives exactly one pulse; the release produces no pulse.
//  - reset clears the synchronisers and counters; accepted level resets to 1 (released).
//  FSM states (state_o): INIT=0 SETUP=1 SEQ=2 PLAY=3 CHECK=4 NEXT=5 EVAL=6 RESULT=7.
//  Transitions:
//  - restart_p: from any state -> INIT. Overrides every other transition.
//  - INIT -> SETUP unconditionally after one cycle.
//  - SETUP -> SEQ on enter_p.
//  - SEQ -> PLAY on end_FPGA.
//  - PLAY -> RESULT on end_time; end_time wins over a simultaneous enter_p.
//  - PLAY -> CHECK on enter_p (end_time low).
//  - CHECK, one cycle:
//    - match=0 -> RESULT.
//    - else end_User=1 -> NEXT.
//    - else -> PLAY.
//  - NEXT -> EVAL after one cycle.
//  - EVAL: win=1 -> RESULT, else -> SEQ. win is sampled one cycle after the E4 pulse.
//  - RESULT -> INIT on enter_p.
//  Outputs are Moore, decoded from the registered state, so a change lands in the cycle after the transition edge.
//  Outputs asserted per state; every output not listed is 0:
//    INIT: R1=1, R2=1.
//    SETUP: E1=1, R2=1.
//    SEQ: E3=1, R2=1.
//    PLAY: E2=1.
//    CHECK: R2=1 (timer restarts for every entry).
//    NEXT: E4=1, R2=1.
//    EVAL: R2=1.
//    RESULT: SEL=1.
//  Reset values: state INIT, so R1=1 and R2=1; E1..E4=0, SEL=0, state_o=0.
//  Reset mid-game: all game progress is dropped. The datapath is re-cleared through R1 in INIT.
//  Status inputs are ignored outside the states that sample them; no latching.
// TESTING (sim with DEBOUNCE_CYCLES=4)
//  - Reset held 3 cycles, then released.
//    Required: state_o=0 with R1=R2=1 while reset is held; state_o=1, E1=1 on the next cycle after release.
//  - KEY[0] bounce 1-0-1-0, then held low 10 cycles.
//    Required: exactly one enter_p; SETUP->SEQ; E3=1 on the following cycle.
//  - Happy round: end_FPGA=1 in SEQ; enter with match=1, end_User=1; win=0.
//    Required state path: PLAY, CHECK, NEXT (E4 high for exactly 1 cycle), EVAL, SEQ.
//  - In PLAY, end_time=1 and enter_p in the same cycle.
//    Required: next state RESULT (7) and SEL=1; CHECK is never entered.
//  - In CHECK, match=0.
//    Required: RESULT. Then enter -> INIT with R1=1 for 1 cycle, then SETUP.
//  - KEY[1] pressed in PLAY.
//    Required: INIT on the cycle after the pulse; E2 drops to 0 at the same time.
//  - Last round: win=1 at EVAL.
//    Required: RESULT. E4 pulsed once only.

Source files
------------

// File: rtl/genius_control.sv
// genius_control
//    Control unit for the Genius memory game. It sits directly upstream of
//    the datapath. It debounces the enter and restart keys and runs the game
//    FSM that sequences the datapath through setup, playback, player entry,
//    checking and the final result display.
//
// Parameters
//    DEBOUNCE_CYCLES : number of consecutive equal samples a key needs before
//                      its new level is accepted (20 ms at 50 MHz by default)
//    P_KEY           : width of the raw KEY bus
//
// Ports
//    CLOCK_50  in   system clock; all logic on the rising edge
//    reset     in   synchronous, active-high; forces INIT
//    KEY       in   raw active-low push-buttons (KEY[0]=enter, KEY[1]=restart)
//    end_FPGA  in   datapath finished showing the sequence
//    end_User  in   player entered the full sequence for this round
//    end_time  in   input timer expired
//    win       in   round counter terminal count
//    match     in   last player entry equals the expected element
//    R1        out  datapath global reset
//    R2        out  timer reset
//    E1        out  SETUP register load
//    E2        out  timer count enable
//    E3        out  FPGA sequence playback enable
//    E4        out  round counter increment (one-cycle pulse)
//    SEL       out  display select: 0 = game info, 1 = result
//    state_o   out  current FSM state, for debug LEDs

module genius_control #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int P_KEY           = 4
) (
   input  logic             CLOCK_50,
   input  logic             reset,
   input  logic [P_KEY-1:0] KEY,
   input  logic             end_FPGA,
   input  logic             end_User,
   input  logic             end_time,
   input  logic             win,
   input  logic             match,
   output logic             R1,
   output logic             R2,
   output logic             E1,
   output logic             E2,
   output logic             E3,
   output logic             E4,
   output logic             SEL,
   output logic [2:0]       state_o
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [2:0] {
      S_INIT   = 3'd0,
      S_SETUP  = 3'd1,
      S_SEQ    = 3'd2,
      S_PLAY   = 3'd3,
      S_CHECK  = 3'd4,
      S_NEXT   = 3'd5,
      S_EVAL   = 3'd6,
      S_RESULT = 3'd7
   } state_t;

   // Key conditioning, index 0 = enter, index 1 = restart
   logic [1:0]       r_sync0;
   logic [1:0]       r_sync1;
   logic [1:0]       r_lvl;
   logic [1:0]       r_press;
   logic [CNT_W-1:0] r_cnt [2];

   logic             w_enter_p;
   logic             w_restart_p;
   logic             w_unused_keys;

   state_t           r_state;
   state_t           w_next;

   // Only the two low keys are used; the rest are deliberately ignored.
   assign w_unused_keys = ^KEY;

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_sync0 <= 2'b11;
         r_sync1 <= 2'b11;
         r_lvl   <= 2'b11;
         r_press <= 2'b00;
         for (int k = 0; k < 2; k++) begin
            r_cnt[k] <= '0;
         end
      end else begin
         r_sync0 <= KEY[1:0];
         r_sync1 <= r_sync0;
         for (int k = 0; k < 2; k++) begin
            r_press[k] <= 1'b0;
            // Any sample equal to the accepted level aborts a pending change,
            // so a bouncing key keeps restarting the count.
            if (r_sync1[k] == r_lvl[k]) begin
               r_cnt[k] <= '0;
            end else if (r_cnt[k] == CNT_MAX) begin
               r_cnt[k]   <= '0;
               r_lvl[k]   <= r_sync1[k];
               // Pulse only on an accepted press (new level low), never on release.
               r_press[k] <= ~r_sync1[k];
            end else begin
               r_cnt[k] <= r_cnt[k] + 1'b1;
            end
         end
      end
   end

   assign w_enter_p   = r_press[0];
   assign w_restart_p = r_press[1];

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_state <= S_INIT;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      R1     = 1'b0;
      R2     = 1'b0;
      E1     = 1'b0;
      E2     = 1'b0;
      E3     = 1'b0;
      E4     = 1'b0;
      SEL    = 1'b0;

      case (r_state)
         S_INIT: begin
            R1     = 1'b1;
            R2     = 1'b1;
            w_next = S_SETUP;
         end
         S_SETUP: begin
            E1 = 1'b1;
            R2 = 1'b1;
            if (w_enter_p) w_next = S_SEQ;
         end
         S_SEQ: begin
            E3 = 1'b1;
            R2 = 1'b1;
            if (end_FPGA) w_next = S_PLAY;
         end
         S_PLAY: begin
            E2 = 1'b1;
            // A timeout beats an entry that arrives in the same cycle.
            if (end_time)       w_next = S_RESULT;
            else if (w_enter_p) w_next = S_CHECK;
         end
         S_CHECK: begin
            // Timer restarts for every entry.
            R2 = 1'b1;
            if (!match)        w_next = S_RESULT;
            else if (end_User) w_next = S_NEXT;
            else               w_next = S_PLAY;
         end
         S_NEXT: begin
            E4     = 1'b1;
            R2     = 1'b1;
            w_next = S_EVAL;
         end
         S_EVAL: begin
            // win reflects the counter one cycle after the E4 increment.
            R2 = 1'b1;
            if (win) w_next = S_RESULT;
            else     w_next = S_SEQ;
         end
         S_RESULT: begin
            SEL = 1'b1;
            if (w_enter_p) w_next = S_INIT;
         end
         default: w_next = S_INIT;
      endcase

      if (w_restart_p) w_next = S_INIT;
   end

   assign state_o = r_state;

endmodule

// File: tb/tb_genius_control.sv
module tb_genius_control;

   localparam int DEB = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] KEY;
   logic       end_FPGA, end_User, end_time, win, match;
   logic       R1, R2, E1, E2, E3, E4, SEL;
   logic [2:0] state_o;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   genius_control #(.DEBOUNCE_CYCLES(DEB), .P_KEY(4)) dut (
      .CLOCK_50 (clk),
      .reset    (reset),
      .KEY      (KEY),
      .end_FPGA (end_FPGA),
      .end_User (end_User),
      .end_time (end_time),
      .win      (win),
      .match    (match),
      .R1       (R1),
      .R2       (R2),
      .E1       (E1),
      .E2       (E2),
      .E3       (E3),
      .E4       (E4),
      .SEL      (SEL),
      .state_o  (state_o)
   );

   // {R1,R2,E1,E2,E3,E4,SEL}
   logic [6:0] outs;
   assign outs = {R1, R2, E1, E2, E3, E4, SEL};

   function automatic logic [6:0] outs_for(input logic [2:0] s);
      case (s)
         3'd0:    return 7'b1100000;
         3'd1:    return 7'b0110000;
         3'd2:    return 7'b0100100;
         3'd3:    return 7'b0001000;
         3'd4:    return 7'b0100000;
         3'd5:    return 7'b0100010;
         3'd6:    return 7'b0100000;
         default: return 7'b0000001;
      endcase
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_state(input string name, input logic [2:0] exp);
      chk({name, "/state"}, 8'(state_o), 8'(exp));
      chk({name, "/outs"}, 8'(outs), 8'(outs_for(exp)));
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_state(input logic [2:0] s, input int maxc, input string name);
      for (int i = 0; i < maxc && state_o !== s; i++) tick();
      chk(name, 8'(state_o), 8'(s));
   endtask

   logic [2:0] lg [20];
   int         e4c;

   task automatic run_log(input int n);
      e4c = 0;
      for (int i = 0; i < n; i++) begin
         tick();
         lg[i] = state_o;
         if (E4 === 1'b1) e4c++;
      end
   endtask

   function automatic int find_check();
      for (int i = 1; i < 14; i++) if (lg[i] == 3'd4) return i;
      return -1;
   endfunction

   task automatic to_play();
      end_FPGA = 1'b1;
      tick();
      end_FPGA = 1'b0;
   endtask

   typedef struct {
      logic [3:0] key;
      logic       efpga, euser, etime, w, m;
      int         ncyc;
      logic [2:0] exp;
   } vec_t;

   vec_t tbl [17];

   initial begin
      int idx;
      logic saw_check;

      tbl[0]  = '{4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,  1, 3'd3};
      tbl[1]  = '{4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  3, 3'd3};
      tbl[2]  = '{4'hE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10, 3'd3};
      tbl[3]  = '{4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10, 3'd3};
      tbl[4]  = '{4'hE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10, 3'd7};
      tbl[5]  = '{4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10, 3'd7};
      tbl[6]  = '{4'hE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20, 3'd1};
      tbl[7]  = '{4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10, 3'd1};
      tbl[8]  = '{4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,  3, 3'd1};
      tbl[9]  = '{4'hE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10, 3'd2};
      tbl[10] = '{4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10, 3'd2};
      tbl[11] = '{4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,  1, 3'd3};
      tbl[12] = '{4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,  1, 3'd7};
      tbl[13] = '{4'hE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10, 3'd1};
      tbl[14] = '{4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10, 3'd1};
      tbl[15] = '{4'hE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10, 3'd2};
      tbl[16] = '{4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10, 3'd2};

      reset = 1'b1; KEY = 4'hF;
      end_FPGA = 1'b0; end_User = 1'b0; end_time = 1'b0; win = 1'b0; match = 1'b0;

      // Reset held 3 cycles, then released
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_state("rst_hold", 3'd0);
      end
      reset = 1'b0;
      tick();
      check_state("rst_release", 3'd1);

      // Bouncing enter, then held low
      KEY[0] = 1'b0; tick();
      KEY[0] = 1'b1; tick();
      KEY[0] = 1'b0;
      wait_state(3'd2, 20, "bounce_to_seq");
      chk("bounce_E3", 8'(E3), 8'd1);
      repeat (8) tick();
      KEY[0] = 1'b1;
      repeat (10) tick();
      check_state("bounce_settled", 3'd2);

      // Table-driven walk through the FSM
      foreach (tbl[i]) begin
         KEY      = tbl[i].key;
         end_FPGA = tbl[i].efpga;
         end_User = tbl[i].euser;
         end_time = tbl[i].etime;
         win      = tbl[i].w;
         match    = tbl[i].m;
         repeat (tbl[i].ncyc) tick();
         check_state($sformatf("vec%0d", i), tbl[i].exp);
      end
      end_FPGA = 1'b0; end_User = 1'b0; end_time = 1'b0; win = 1'b0; match = 1'b0;

      // Happy round: PLAY, CHECK, NEXT, EVAL, SEQ
      to_play();
      match = 1'b1; end_User = 1'b1; win = 1'b0;
      KEY[0] = 1'b0;
      run_log(14);
      KEY[0] = 1'b1;
      idx = find_check();
      chk("happy_found_check", 8'(idx >= 1), 8'd1);
      if (idx < 1) idx = 1;
      chk("happy_prev_play", 8'(lg[idx-1]), 8'd3);
      chk("happy_next",      8'(lg[idx+1]), 8'd5);
      chk("happy_eval",      8'(lg[idx+2]), 8'd6);
      chk("happy_seq",       8'(lg[idx+3]), 8'd2);
      chk("happy_e4_once",   8'(e4c), 8'd1);
      repeat (10) tick();
      check_state("happy_settled", 3'd2);
      match = 1'b0; end_User = 1'b0;

      // Timeout and entry in the same cycle
      to_play();
      saw_check = 1'b0;
      KEY[0] = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (state_o == 3'd4) saw_check = 1'b1;
      end
      end_time = 1'b1;
      tick();
      end_time = 1'b0;
      check_state("timeout_wins", 3'd7);
      KEY[0] = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (state_o == 3'd4) saw_check = 1'b1;
      end
      chk("timeout_no_check", 8'(saw_check), 8'd0);
      check_state("timeout_hold", 3'd7);

      // RESULT -> INIT for exactly one cycle -> SETUP
      KEY[0] = 1'b0;
      wait_state(3'd0, 20, "result_to_init");
      chk("init_R1", 8'(R1), 8'd1);
      tick();
      check_state("init_to_setup", 3'd1);
      repeat (6) tick();
      KEY[0] = 1'b1;
      repeat (10) tick();
      check_state("setup_hold", 3'd1);

      // Restart pressed in PLAY
      KEY[0] = 1'b0;
      wait_state(3'd2, 20, "setup_to_seq2");
      repeat (6) tick();
      KEY[0] = 1'b1;
      repeat (10) tick();
      to_play();
      check_state("play_before_restart", 3'd3);
      KEY[1] = 1'b0;
      for (int i = 0; i < 20 && state_o == 3'd3; i++) begin
         tick();
         if (state_o == 3'd3) chk("play_E2_held", 8'(E2), 8'd1);
      end
      chk("restart_init", 8'(state_o), 8'd0);
      chk("restart_E2_low", 8'(E2), 8'd0);
      chk("restart_R1", 8'(R1), 8'd1);
      tick();
      check_state("restart_setup", 3'd1);
      repeat (6) tick();
      KEY[1] = 1'b1;
      repeat (10) tick();
      check_state("restart_settled", 3'd1);

      // Last round: win at EVAL
      KEY[0] = 1'b0;
      wait_state(3'd2, 20, "setup_to_seq3");
      repeat (6) tick();
      KEY[0] = 1'b1;
      repeat (10) tick();
      to_play();
      match = 1'b1; end_User = 1'b1; win = 1'b1;
      KEY[0] = 1'b0;
      run_log(14);
      KEY[0] = 1'b1;
      idx = find_check();
      chk("win_found_check", 8'(idx >= 1), 8'd1);
      if (idx < 1) idx = 1;
      chk("win_next",    8'(lg[idx+1]), 8'd5);
      chk("win_eval",    8'(lg[idx+2]), 8'd6);
      chk("win_result",  8'(lg[idx+3]), 8'd7);
      chk("win_e4_once", 8'(e4c), 8'd1);
      repeat (10) tick();
      check_state("win_hold", 3'd7);
      match = 1'b0; end_User = 1'b0; win = 1'b0;

      // Reset mid-game
      reset = 1'b1;
      tick();
      check_state("midreset_init", 3'd0);
      reset = 1'b0;
      tick();
      check_state("midreset_setup", 3'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
